zbt_arbiter: RTL and testbench
==============================

ZBT_ARBITER -- requirements
Module: zbt_arbiter

Interface
REQ-001 Parameter ADDR_W, default 19, ZBT word-address width.
REQ-002 Parameter DATA_W, default 36, ZBT word width.
REQ-003 Parameter RD_LAT, default 2, cycles from mem_addr driven (read) to valid mem_read.
REQ-004 Parameter DISP_BURST, default 8, max consecutive display grants while a writer waits.
REQ-005 Port clock  in  1  sole clock, all state on rising edge.
REQ-006 Port reset  in  1  asynchronous, active-low reset.
REQ-007 Port disp_req  in  1  display read request; disp_addr  in  ADDR_W  read address.
REQ-008 Port disp_gnt  out  1  display request accepted this cycle.
REQ-009 Port disp_rdata  out  DATA_W  read data; disp_rvalid  out  1  disp_rdata valid.
REQ-010 Port cam_req  in  1; cam_addr  in  ADDR_W; cam_wdata  in  DATA_W  camera write request.
REQ-011 Port cam_gnt  out  1  camera write accepted this cycle.
REQ-012 Port pat_req  in  1; pat_addr  in  ADDR_W; pat_wdata  in  DATA_W  pattern/processor write request.
REQ-013 Port pat_gnt  out  1  pattern write accepted this cycle.
REQ-014 Port mem_addr  out  ADDR_W; mem_write  out  DATA_W; mem_wr  out  1  registered ZBT command.
REQ-015 Port mem_read  in  DATA_W  ZBT read data.

Function
REQ-016 Grants combinational from current req and registered arbitration state; at most one of disp_gnt/cam_gnt/pat_gnt high per cycle.
REQ-017 Transfer occurs in a cycle where req and gnt both high; requester holds req/addr/wdata until granted; gnt never high without its req.
REQ-018 Priority: display over writers, except when burst counter == DISP_BURST and any writer requests, then writer wins that cycle.
REQ-019 Burst counter: +1 per display grant (saturating at DISP_BURST); cleared on any writer grant or any cycle with disp_req low.
REQ-020 Writers round-robin: last_wr pointer selects the other writer when both request; pointer updates only on a writer grant.
REQ-021 Cycle after a write transfer: mem_addr = granted addr, mem_write = granted wdata, mem_wr = 1.
REQ-022 Cycle after a read transfer: mem_addr = disp_addr, mem_wr = 0, mem_write holds previous value.
REQ-023 Cycle after no transfer: mem_wr = 0, mem_addr and mem_write hold.
REQ-024 Read tag pipeline of depth RD_LAT+1; disp_rvalid high exactly RD_LAT+1 cycles after the transfer cycle, disp_rdata = mem_read sampled that cycle, registered.
REQ-025 Back-to-back reads every cycle produce back-to-back disp_rvalid in order; no read dropped, no bubble inserted.
REQ-026 Read after write to same address in consecutive cycles returns new data (ZBT ordering; arbiter adds no reordering).
REQ-027 Address/data widths pass unmodified; no arithmetic on addresses.

Reset
REQ-028 reset low asynchronously forces mem_wr = 0, mem_addr = 0, mem_write = 0, disp_rvalid = 0, disp_rdata = 0, burst counter = 0, last_wr = pat (cam preferred first), read pipeline cleared.
REQ-029 While reset low all gnt outputs 0; reads in flight at reset are discarded, never returned.
REQ-030 First grant possible in the first cycle after reset deasserts.

Verification
REQ-031 Only cam_req, addr 0x00010, data 0xFFFFFFFFF -> cam_gnt same cycle; next cycle mem_wr=1, mem_addr=0x00010, mem_write=0xFFFFFFFFF.
REQ-032 disp_req held 20 cycles, cam_req high throughout -> disp_gnt 8 cycles, cam_gnt 1 cycle, pattern repeats; disp_rvalid count equals disp_gnt count.
REQ-033 cam_req and pat_req held, no display -> grants alternate cam, pat, cam, ...; mem_wr=1 every cycle.
REQ-034 Read addr 0x25800 at cycle t, RD_LAT=2, memory model returns 0x123456789 -> disp_rvalid only at t+3, disp_rdata=0x123456789.
REQ-035 Read granted, reset pulsed low one cycle later -> all outputs 0 immediately; disp_rvalid never asserts for that read.
REQ-036 Random req/addr/data for 10000 cycles vs. memory scoreboard -> one-hot-or-zero grants, all read data matches, no writer waits > DISP_BURST+2 cycles.

Source files
------------

// File: rtl/zbt_arbiter.sv
// zbt_arbiter: arbitrates one display read port and two write ports
// (camera, pattern/processor) onto a single ZBT SRAM command interface.
//
// Ports:
//   clock, reset        sole clock; asynchronous active-low reset
//   disp_req/disp_addr  display read request and word address
//   disp_gnt            display request accepted this cycle
//   disp_rdata/rvalid   registered read return, RD_LAT+1 cycles after transfer
//   cam_req/addr/wdata  camera write request, cam_gnt accepts it
//   pat_req/addr/wdata  pattern write request, pat_gnt accepts it
//   mem_addr/mem_write  registered ZBT address / write data
//   mem_wr              registered ZBT write strobe (0 = read or idle)
//   mem_read            ZBT read data, sampled RD_LAT cycles after the transfer
//
// Display has priority, but once DISP_BURST consecutive display grants have
// been issued a waiting writer takes the next slot. Writers alternate when
// both request.

module zbt_arbiter #(
   parameter int unsigned ADDR_W     = 19,
   parameter int unsigned DATA_W     = 36,
   parameter int unsigned RD_LAT     = 2,
   parameter int unsigned DISP_BURST = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic              disp_gnt,
   output logic [DATA_W-1:0] disp_rdata,
   output logic              disp_rvalid,
   input  logic              cam_req,
   input  logic [ADDR_W-1:0] cam_addr,
   input  logic [DATA_W-1:0] cam_wdata,
   output logic              cam_gnt,
   input  logic              pat_req,
   input  logic [ADDR_W-1:0] pat_addr,
   input  logic [DATA_W-1:0] pat_wdata,
   output logic              pat_gnt,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_write,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_read
);

   localparam int unsigned      CNT_W     = $clog2(DISP_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(DISP_BURST);

   typedef enum logic {LAST_CAM, LAST_PAT} last_wr_t;

   last_wr_t          r_last_wr;
   logic [CNT_W-1:0]  r_burst;
   logic [RD_LAT:0]   r_tag;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_write;
   logic              r_mem_wr;
   logic [DATA_W-1:0] r_rdata;

   logic w_wr_any;
   logic w_force_wr;
   logic w_disp_gnt;
   logic w_wr_slot;
   logic w_cam_pick;
   logic w_cam_gnt;
   logic w_pat_gnt;

   // Grants are gated by reset directly so nothing is accepted while the
   // registered state is being held clear.
   always_comb begin
      w_wr_any   = cam_req | pat_req;
      w_force_wr = (r_burst == BURST_MAX) && w_wr_any;
      w_disp_gnt = reset && disp_req && !w_force_wr;
      w_wr_slot  = reset && w_wr_any && !w_disp_gnt;
      // Camera wins a tie only when the pattern port was served last.
      w_cam_pick = cam_req && (!pat_req || (r_last_wr == LAST_PAT));
      w_cam_gnt  = w_wr_slot && w_cam_pick;
      w_pat_gnt  = w_wr_slot && !w_cam_pick;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_last_wr   <= LAST_PAT;
         r_burst     <= '0;
         r_tag       <= '0;
         r_mem_addr  <= '0;
         r_mem_write <= '0;
         r_mem_wr    <= 1'b0;
         r_rdata     <= '0;
      end else begin
         r_mem_wr <= w_cam_gnt | w_pat_gnt;

         if (w_cam_gnt) begin
            r_mem_addr  <= cam_addr;
            r_mem_write <= cam_wdata;
            r_last_wr   <= LAST_CAM;
         end else if (w_pat_gnt) begin
            r_mem_addr  <= pat_addr;
            r_mem_write <= pat_wdata;
            r_last_wr   <= LAST_PAT;
         end else if (w_disp_gnt) begin
            r_mem_addr <= disp_addr;
         end

         if (w_cam_gnt || w_pat_gnt || !disp_req) begin
            r_burst <= '0;
         end else if (w_disp_gnt && (r_burst != BURST_MAX)) begin
            r_burst <= r_burst + CNT_W'(1);
         end

         // Tag bit k is set k+1 cycles after a read transfer. Read data is
         // captured one stage before the final tag so that data and valid
         // leave together from registers.
         r_tag <= {r_tag[RD_LAT-1:0], w_disp_gnt};
         if (r_tag[RD_LAT-1]) begin
            r_rdata <= mem_read;
         end
      end
   end

   assign disp_gnt    = w_disp_gnt;
   assign cam_gnt     = w_cam_gnt;
   assign pat_gnt     = w_pat_gnt;
   assign mem_addr    = r_mem_addr;
   assign mem_write   = r_mem_write;
   assign mem_wr      = r_mem_wr;
   assign disp_rdata  = r_rdata;
   assign disp_rvalid = r_tag[RD_LAT];

endmodule

// File: tb/tb_zbt_arbiter.sv
module tb_zbt_arbiter;

   localparam int unsigned ADDR_W = 19;
   localparam int unsigned DATA_W = 36;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              disp_req = 1'b0;
   logic [ADDR_W-1:0] disp_addr = '0;
   logic              disp_gnt;
   logic [DATA_W-1:0] disp_rdata;
   logic              disp_rvalid;
   logic              cam_req = 1'b0;
   logic [ADDR_W-1:0] cam_addr = '0;
   logic [DATA_W-1:0] cam_wdata = '0;
   logic              cam_gnt;
   logic              pat_req = 1'b0;
   logic [ADDR_W-1:0] pat_addr = '0;
   logic [DATA_W-1:0] pat_wdata = '0;
   logic              pat_gnt;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_write;
   logic              mem_wr;
   logic [DATA_W-1:0] mem_read = '0;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   logic [DATA_W-1:0] mem_arr [logic [ADDR_W-1:0]];

   zbt_arbiter #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .RD_LAT(2),
      .DISP_BURST(8)
   ) dut (
      .clock(clock),
      .reset(reset),
      .disp_req(disp_req),
      .disp_addr(disp_addr),
      .disp_gnt(disp_gnt),
      .disp_rdata(disp_rdata),
      .disp_rvalid(disp_rvalid),
      .cam_req(cam_req),
      .cam_addr(cam_addr),
      .cam_wdata(cam_wdata),
      .cam_gnt(cam_gnt),
      .pat_req(pat_req),
      .pat_addr(pat_addr),
      .pat_wdata(pat_wdata),
      .pat_gnt(pat_gnt),
      .mem_addr(mem_addr),
      .mem_write(mem_write),
      .mem_wr(mem_wr),
      .mem_read(mem_read)
   );

   always #5 clock = ~clock;

   // SRAM model: writes land at the edge closing a mem_wr cycle; read data
   // for the address on mem_addr appears in the following cycle.
   always @(posedge clock) begin
      if (mem_wr) begin
         mem_arr[mem_addr] = mem_write;
      end else if (mem_arr.exists(mem_addr)) begin
         mem_read <= mem_arr[mem_addr];
      end else begin
         mem_read <= '0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk_gnt(input string tag, input logic d, input logic c, input logic p);
      chk({tag, "_gnt"}, {61'd0, disp_gnt, cam_gnt, pat_gnt}, {61'd0, d, c, p});
   endtask

   initial begin
      int unsigned rv_cnt;
      int unsigned dg_cnt;
      logic exp_cam;
      logic exp_pat;

      mem_arr[19'h25800] = 36'h123456789;
      mem_arr[19'h00200] = 36'h111111111;
      mem_arr[19'h00201] = 36'h222222222;
      mem_arr[19'h00202] = 36'h333333333;

      // Reset: outputs cleared, grants suppressed even with requests up
      #1 reset = 1'b0;
      disp_req = 1'b1;
      cam_req  = 1'b1;
      #1;
      chk_gnt("rst_hold", 1'b0, 1'b0, 1'b0);
      chk("rst_mem_wr", 64'(mem_wr), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_mem_write", 64'(mem_write), 64'd0);
      chk("rst_rvalid", 64'(disp_rvalid), 64'd0);
      chk("rst_rdata", 64'(disp_rdata), 64'd0);
      disp_req = 1'b0;
      cam_req  = 1'b0;
      tick();
      tick();
      reset = 1'b1;

      // Lone camera write, first cycle after reset
      cam_req   = 1'b1;
      cam_addr  = 19'h00010;
      cam_wdata = 36'hFFFFFFFFF;
      #1 chk_gnt("cam_only", 1'b0, 1'b1, 1'b0);
      tick();
      cam_req = 1'b0;
      chk("cam_only_wr", 64'(mem_wr), 64'd1);
      chk("cam_only_addr", 64'(mem_addr), 64'h10);
      chk("cam_only_data", 64'(mem_write), 64'hFFFFFFFFF);
      tick();
      chk("idle_wr", 64'(mem_wr), 64'd0);
      chk("idle_addr_hold", 64'(mem_addr), 64'h10);

      // Single read, data returns exactly three cycles after the transfer
      disp_req  = 1'b1;
      disp_addr = 19'h25800;
      #1 chk_gnt("rd1", 1'b1, 1'b0, 1'b0);
      tick();
      disp_req = 1'b0;
      chk("rd1_addr", 64'(mem_addr), 64'h25800);
      chk("rd1_wr", 64'(mem_wr), 64'd0);
      chk("rd1_wdata_hold", 64'(mem_write), 64'hFFFFFFFFF);
      chk("rd1_rv_t1", 64'(disp_rvalid), 64'd0);
      tick();
      chk("rd1_rv_t2", 64'(disp_rvalid), 64'd0);
      tick();
      chk("rd1_rv_t3", 64'(disp_rvalid), 64'd1);
      chk("rd1_rdata", 64'(disp_rdata), 64'h123456789);
      tick();
      chk("rd1_rv_t4", 64'(disp_rvalid), 64'd0);

      // Write then read of the same address on consecutive cycles
      cam_req   = 1'b1;
      cam_addr  = 19'h00123;
      cam_wdata = 36'hABCDE0123;
      #1 chk_gnt("raw_w", 1'b0, 1'b1, 1'b0);
      tick();
      cam_req   = 1'b0;
      disp_req  = 1'b1;
      disp_addr = 19'h00123;
      #1 chk_gnt("raw_r", 1'b1, 1'b0, 1'b0);
      tick();
      disp_req = 1'b0;
      tick();
      tick();
      chk("raw_rv", 64'(disp_rvalid), 64'd1);
      chk("raw_rdata", 64'(disp_rdata), 64'hABCDE0123);

      // Back-to-back reads come back back-to-back and in order
      disp_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         disp_addr = 19'h00200 + 19'(i);
         #1 chk_gnt("b2b", 1'b1, 1'b0, 1'b0);
         tick();
      end
      disp_req = 1'b0;
      chk("b2b_rv0", 64'(disp_rvalid), 64'd1);
      chk("b2b_d0", 64'(disp_rdata), 64'h111111111);
      tick();
      chk("b2b_rv1", 64'(disp_rvalid), 64'd1);
      chk("b2b_d1", 64'(disp_rdata), 64'h222222222);
      tick();
      chk("b2b_rv2", 64'(disp_rvalid), 64'd1);
      chk("b2b_d2", 64'(disp_rdata), 64'h333333333);
      tick();
      chk("b2b_rv3", 64'(disp_rvalid), 64'd0);

      // Both writers held: camera served last, so pattern goes first
      cam_req   = 1'b1;
      cam_addr  = 19'h00300;
      cam_wdata = 36'h00000000C;
      pat_req   = 1'b1;
      pat_addr  = 19'h00400;
      pat_wdata = 36'h00000000D;
      for (int k = 0; k < 4; k++) begin
         exp_pat = (k % 2 == 0);
         #1 chk_gnt("rr", 1'b0, !exp_pat, exp_pat);
         tick();
         chk("rr_wr", 64'(mem_wr), 64'd1);
         chk("rr_addr", 64'(mem_addr), exp_pat ? 64'h400 : 64'h300);
      end
      pat_req = 1'b0;

      // Display held with camera waiting: 8 display grants, then 1 camera
      cam_addr  = 19'h00500;
      cam_wdata = 36'h0AAAAAAAA;
      disp_req  = 1'b1;
      disp_addr = 19'h00200;
      rv_cnt = 0;
      dg_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         exp_cam = (i % 9 == 8);
         #1 chk_gnt("burst", !exp_cam, exp_cam, 1'b0);
         if (disp_gnt) dg_cnt++;
         tick();
         if (disp_rvalid) rv_cnt++;
      end
      disp_req = 1'b0;
      cam_req  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (disp_rvalid) rv_cnt++;
      end
      chk("burst_dgnt_cnt", 64'(dg_cnt), 64'd18);
      chk("burst_rvalid_cnt", 64'(rv_cnt), 64'd18);

      // Reset one cycle after a read grant: the read never returns
      disp_req  = 1'b1;
      disp_addr = 19'h25800;
      #1 chk_gnt("rstrd", 1'b1, 1'b0, 1'b0);
      tick();
      disp_req = 1'b0;
      chk("rstrd_pre_addr", 64'(mem_addr), 64'h25800);
      reset   = 1'b0;
      cam_req = 1'b1;
      #1;
      chk_gnt("rstrd_hold", 1'b0, 1'b0, 1'b0);
      chk("rstrd_mem_addr", 64'(mem_addr), 64'd0);
      chk("rstrd_mem_write", 64'(mem_write), 64'd0);
      chk("rstrd_mem_wr", 64'(mem_wr), 64'd0);
      chk("rstrd_rvalid", 64'(disp_rvalid), 64'd0);
      chk("rstrd_rdata", 64'(disp_rdata), 64'd0);
      cam_req = 1'b0;
      tick();
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("rstrd_no_rv", 64'(disp_rvalid), 64'd0);
      end

      // Pointer reset: camera is preferred on the first tie after reset
      cam_req = 1'b1;
      pat_req = 1'b1;
      #1 chk_gnt("rst_rr", 1'b0, 1'b1, 1'b0);
      tick();
      #1 chk_gnt("rst_rr2", 1'b0, 1'b0, 1'b1);
      cam_req = 1'b0;
      pat_req = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
